// File: rtl/button_event_parser.sv
// button_event_parser: multi-channel button front end.
// Each channel is synchronized, debounced on a shared sample tick and then
// tracked by a small FSM that emits single-cycle press / release /
// long-press / auto-repeat pulses.
// Optional feature macro: BUTTON_AUTOREPEAT_EN (repeat counter and repeat
// pulses). When it is undefined, repeat_ev is tied to 0.
// "release" and "repeat" are SystemVerilog keywords, so those event ports
// are named release_ev and repeat_ev.
module button_event_parser #(
   parameter int WIDTH          = 4,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int PULSE_CNT_MAX  = 150,
   parameter int HOLD_TICKS     = 2000,
   parameter int REPEAT_TICKS   = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_ev,
   output logic [WIDTH-1:0] long_press,
   output logic [WIDTH-1:0] repeat_ev
);

   // Counter widths: each counter holds 0..MAX inclusive.
   localparam int SW = $clog2(SAMPLE_CNT_MAX + 1);
   localparam int PW = $clog2(PULSE_CNT_MAX + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);

   localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [PW-1:0] PULSE_MAX = PW'(PULSE_CNT_MAX);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int            RW         = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] REPEAT_MAX = RW'(REPEAT_TICKS);
`endif

   // Reject parameter sets the counters cannot represent.
   if (WIDTH < 1 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
       HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
      $error("button_event_parser: all parameters must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DOWN = 2'd1,
      ST_HELD = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Two-flop synchronizer for every raw button input
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] sync_a;
   logic [WIDTH-1:0] sync_b;

   // Shift raw levels through two flops to settle metastability.
   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge value of its neighbours, exactly like the hardware does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= in;
         sync_b <= sync_a;
      end
   end

   // ---------------------------------------------------------------------
   // Shared sample tick: counts 0..SAMPLE_CNT_MAX-1 and wraps
   // ---------------------------------------------------------------------
   logic [SW-1:0] samp_cnt;
   logic          tick;

   assign tick = (samp_cnt == SAMP_LAST);

   // Free-running sample divider; tick marks its last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_cnt <= '0;
      end else if (tick) begin
         samp_cnt <= '0;
      end else begin
         samp_cnt <= samp_cnt + SW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Per-channel debounce and event FSM
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      logic [PW-1:0] db_cnt;
      logic [PW-1:0] db_cnt_d;
      logic          lvl_d;
      logic          level_q;
      logic          rise;
      logic          fall;

      state_t        state_q;
      state_t        state_d;
      logic [HW-1:0] hold_q;
      logic [HW-1:0] hold_d;

      logic          press_d,   press_q;
      logic          release_d, release_q;
      logic          long_d,    long_q;

`ifdef BUTTON_AUTOREPEAT_EN
      logic [RW-1:0] rpt_q;
      logic [RW-1:0] rpt_d;
      logic          repeat_d,  repeat_q;
`endif

      // Debounce: saturating count of high samples, cleared by any low one.
      // NOTE: every signal written in always_comb gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      always_comb begin
         db_cnt_d = db_cnt;
         if (tick) begin
            if (!sync_b[g]) begin
               db_cnt_d = '0;
            end else if (db_cnt != PULSE_MAX) begin
               db_cnt_d = db_cnt + PW'(1);
            end
         end
      end

      // Level is decided from the next count so that level and the
      // press/release pulse it triggers are registered on the same edge.
      assign lvl_d = (db_cnt_d == PULSE_MAX);
      assign rise  = lvl_d & ~level_q;
      assign fall  = ~lvl_d & level_q;

      // Next-state and event decode; release has priority over hold events.
      always_comb begin
         state_d   = state_q;
         hold_d    = hold_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
         rpt_d     = rpt_q;
         repeat_d  = 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  press_d = 1'b1;
                  hold_d  = '0;
                  state_d = ST_DOWN;
               end
            end
            ST_DOWN: begin
               if (fall) begin
                  release_d = 1'b1;
                  state_d   = ST_IDLE;
               end else if (tick) begin
                  hold_d = hold_q + HW'(1);
                  if ((hold_q + HW'(1)) == HOLD_MAX) begin
                     long_d  = 1'b1;
                     state_d = ST_HELD;
`ifdef BUTTON_AUTOREPEAT_EN
                     rpt_d   = '0;
`endif
                  end
               end
            end
            ST_HELD: begin
               if (fall) begin
                  release_d = 1'b1;
                  state_d   = ST_IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
               end else if (tick) begin
                  if ((rpt_q + RW'(1)) == REPEAT_MAX) begin
                     repeat_d = 1'b1;
                     rpt_d    = '0;
                  end else begin
                     rpt_d = rpt_q + RW'(1);
                  end
`endif
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Channel state register; all event outputs are registered here.
      // NOTE: every counter and state flop is in the async reset, so a reset
      // mid-press restarts debouncing from zero.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt    <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q     <= '0;
            repeat_q  <= 1'b0;
`endif
         end else begin
            db_cnt    <= db_cnt_d;
            level_q   <= lvl_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
            repeat_q  <= repeat_d;
`endif
         end
      end

      assign level[g]      = level_q;
      assign press[g]      = press_q;
      assign release_ev[g] = release_q;
      assign long_press[g] = long_q;
`ifdef BUTTON_AUTOREPEAT_EN
      assign repeat_ev[g]  = repeat_q;
`else
      assign repeat_ev[g]  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_event_parser.sv
// Self-checking bench for button_event_parser (WIDTH=2, small counters).
// Expected events go into per-channel queues with a latency window when the
// stimulus is driven; a negedge monitor pops and compares each DUT pulse.
`timescale 1ns/1ps
module tb_button_event_parser;

   localparam int WIDTH          = 2;
   localparam int SAMPLE_CNT_MAX = 4;
   localparam int PULSE_CNT_MAX  = 3;
   localparam int HOLD_TICKS     = 10;
   localparam int REPEAT_TICKS   = 5;

   localparam int PRESS_LO = (PULSE_CNT_MAX - 1) * SAMPLE_CNT_MAX + 3;
   localparam int PRESS_HI = PULSE_CNT_MAX * SAMPLE_CNT_MAX + 3;
   localparam int REL_LO   = 3;
   localparam int REL_HI   = SAMPLE_CNT_MAX + 3;
   localparam int LONG_DLY = HOLD_TICKS * SAMPLE_CNT_MAX;
   localparam int RPT_DLY  = REPEAT_TICKS * SAMPLE_CNT_MAX;

   typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT} ev_t;

   // base >= 0: window measured from that cycle; base < 0: from the previous
   // observed event on the same channel.
   typedef struct {
      ev_t kind;
      int  base;
      int  lo;
      int  hi;
   } exp_t;

   typedef struct {
      logic [1:0] in_v;
      int         cycles;
      logic [1:0] exp_level;
   } vec_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] btn   = 2'b11;
   logic [WIDTH-1:0] level, press, release_ev, long_press, repeat_ev;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_ev[WIDTH];
   exp_t q0[$];
   exp_t q1[$];
   vec_t vecs[8];

   button_event_parser #(
      .WIDTH          (WIDTH),
      .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
      .PULSE_CNT_MAX  (PULSE_CNT_MAX),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (btn),
      .level      (level),
      .press      (press),
      .release_ev (release_ev),
      .long_press (long_press),
      .repeat_ev  (repeat_ev)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic ok, input string detail);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic int qsize(input int ch);
      return (ch == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push(input int ch, input ev_t kind, input int base,
                       input int lo, input int hi);
      exp_t e;
      e.kind = kind;
      e.base = base;
      e.lo   = lo;
      e.hi   = hi;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   task automatic handle_ev(input int ch, input ev_t kind);
      exp_t e;
      int   r;
      int   d;
      check($sformatf("expected_%s_ch%0d", kind.name(), ch), qsize(ch) != 0,
            $sformatf("got %s at cycle %0d, required no event", kind.name(), cyc));
      if (qsize(ch) != 0) begin
         if (ch == 0) e = q0.pop_front();
         else         e = q1.pop_front();
         r = (e.base >= 0) ? e.base : last_ev[ch];
         d = cyc - r;
         check($sformatf("event_%s_ch%0d", e.kind.name(), ch),
               (e.kind == kind) && (d >= e.lo) && (d <= e.hi),
               $sformatf("got %s at +%0d, required %s in [%0d,%0d]",
                         kind.name(), d, e.kind.name(), e.lo, e.hi));
      end
      last_ev[ch] = cyc;
   endtask

   // Monitor: sample outputs mid-cycle and score every pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int ch = 0; ch < WIDTH; ch++) begin
            int n;
            n = int'(press[ch]) + int'(release_ev[ch]) +
                int'(long_press[ch]) + int'(repeat_ev[ch]);
            if (n != 0) begin
               check($sformatf("single_event_ch%0d", ch), n == 1,
                     $sformatf("got %0d simultaneous events, required 1", n));
               if (press[ch]) begin
                  check("press_with_level", level[ch] == 1'b1,
                        $sformatf("level=%b, required 1", level[ch]));
                  handle_ev(ch, EV_PRESS);
               end
               if (release_ev[ch]) begin
                  check("release_with_level", level[ch] == 1'b0,
                        $sformatf("level=%b, required 0", level[ch]));
                  handle_ev(ch, EV_RELEASE);
               end
               if (long_press[ch]) handle_ev(ch, EV_LONG);
               if (repeat_ev[ch])  handle_ev(ch, EV_REPEAT);
            end
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input int ch, input int budget);
      int k;
      k = 0;
      while (qsize(ch) != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("drain_ch%0d", ch), qsize(ch) == 0,
            $sformatf("%0d events still pending after %0d cycles, required 0",
                      qsize(ch), budget));
   endtask

   task automatic check_all_zero(input string name);
      check(name, {level, press, release_ev, long_press, repeat_ev} == '0,
            $sformatf("lvl=%b prs=%b rel=%b lng=%b rpt=%b, required all 0",
                      level, press, release_ev, long_press, repeat_ev));
   endtask

   task automatic check_level(input string name, input logic [1:0] exp_v);
      check(name, level == exp_v,
            $sformatf("level=%b, required %b", level, exp_v));
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         base;
      int         e_cyc;
      logic [1:0] prev;

      last_ev[0] = 0;
      last_ev[1] = 0;

      // Short presses and releases, each held well under the long-press time.
      vecs[0] = '{2'b01, 30, 2'b01};
      vecs[1] = '{2'b00, 30, 2'b00};
      vecs[2] = '{2'b10, 30, 2'b10};
      vecs[3] = '{2'b01, 30, 2'b01};
      vecs[4] = '{2'b10, 30, 2'b10};
      vecs[5] = '{2'b00, 30, 2'b00};
      vecs[6] = '{2'b11, 30, 2'b11};
      vecs[7] = '{2'b00, 30, 2'b00};

      // Reset held with both buttons pressed: outputs stay 0.
      run(3);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      base  = cyc;
      push(0, EV_PRESS, base, PRESS_LO, PRESS_HI);
      push(1, EV_PRESS, base, PRESS_LO, PRESS_HI);
      wait_drain(0, 30);
      wait_drain(1, 30);
      run(2);
      check_level("reset_level_after_press", 2'b11);
      btn  = 2'b00;
      base = cyc;
      push(0, EV_RELEASE, base, REL_LO, REL_HI);
      push(1, EV_RELEASE, base, REL_LO, REL_HI);
      wait_drain(0, 20);
      wait_drain(1, 20);
      check_level("reset_level_after_release", 2'b00);

      // Table-driven presses/releases on both channels.
      for (int i = 0; i < 8; i++) begin
         prev = btn;
         btn  = vecs[i].in_v;
         base = cyc;
         for (int ch = 0; ch < WIDTH; ch++) begin
            if (!prev[ch] && btn[ch]) push(ch, EV_PRESS, base, PRESS_LO, PRESS_HI);
            if (prev[ch] && !btn[ch]) push(ch, EV_RELEASE, base, REL_LO, REL_HI);
         end
         run(vecs[i].cycles);
         check_level($sformatf("vec%0d_level", i), vecs[i].exp_level);
      end

      // Bounce: toggling every 3 cycles never gives 3 high ticks in a row.
      for (int i = 0; i < 20; i++) begin
         btn[0] = (i % 2 == 0);
         run(3);
      end
      btn[0] = 1'b1;
      base   = cyc;
      push(0, EV_PRESS, base, 3, PRESS_HI);
      wait_drain(0, 20);
      run(15);
      check_level("bounce_level", 2'b01);
      btn[0] = 1'b0;
      base   = cyc;
      push(0, EV_RELEASE, base, REL_LO, REL_HI);
      wait_drain(0, 20);

      // Long press, then auto-repeat when the feature is built in.
      run(10);
      btn[0] = 1'b1;
      base   = cyc;
      push(0, EV_PRESS, base, PRESS_LO, PRESS_HI);
      push(0, EV_LONG, -1, LONG_DLY, LONG_DLY);
`ifdef BUTTON_AUTOREPEAT_EN
      push(0, EV_REPEAT, -1, RPT_DLY, RPT_DLY);
      push(0, EV_REPEAT, -1, RPT_DLY, RPT_DLY);
      push(0, EV_REPEAT, -1, RPT_DLY, RPT_DLY);
      wait_drain(0, PRESS_HI + LONG_DLY + 3 * RPT_DLY + 10);
`else
      wait_drain(0, PRESS_HI + LONG_DLY + 10);
      run(3 * RPT_DLY);
`endif
      check_level("long_level", 2'b01);
      btn[0] = 1'b0;
      base   = cyc;
      push(0, EV_RELEASE, base, REL_LO, REL_HI);
      wait_drain(0, 20);
      run(2 * RPT_DLY);

      // Level falls on exactly the tick that would complete the hold.
      btn[0] = 1'b1;
      base   = cyc;
      push(0, EV_PRESS, base, PRESS_LO, PRESS_HI);
      wait_drain(0, 20);
      e_cyc = last_ev[0];
      while (cyc < e_cyc + LONG_DLY - 3) @(negedge clk);
      btn[0] = 1'b0;
      push(0, EV_RELEASE, e_cyc, LONG_DLY, LONG_DLY);
      wait_drain(0, 20);
      run(LONG_DLY + 10);
      check_level("threshold_level", 2'b00);

      // Channel 1 held across a channel 0 press, then a mid-hold reset.
      btn[1] = 1'b1;
      base   = cyc;
      push(1, EV_PRESS, base, PRESS_LO, PRESS_HI);
      run(20);
      btn[0] = 1'b1;
      base   = cyc;
      push(0, EV_PRESS, base, PRESS_LO, PRESS_HI);
      run(20);
      wait_drain(0, 1);
      wait_drain(1, 1);
      check_level("indep_level", 2'b11);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("midreset_outputs");
      rst_n = 1'b1;
      base  = cyc;
      push(0, EV_PRESS, base, PRESS_LO, PRESS_HI);
      push(1, EV_PRESS, base, PRESS_LO, PRESS_HI);
      wait_drain(0, 30);
      wait_drain(1, 30);
      run(5);
      check_level("repress_level", 2'b11);
      btn  = 2'b00;
      base = cyc;
      push(0, EV_RELEASE, base, REL_LO, REL_HI);
      push(1, EV_RELEASE, base, REL_LO, REL_HI);
      wait_drain(0, 20);
      wait_drain(1, 20);
      run(10);
      check_level("final_level", 2'b00);

      check("queue_empty_ch0", q0.size() == 0,
            $sformatf("%0d pending, required 0", q0.size()));
      check("queue_empty_ch1", q1.size() == 0,
            $sformatf("%0d pending, required 0", q1.size()));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
